// File: rtl/fifo_uart_tx_if.sv
// -----------------------------------------------------------------------------
// fifo_uart_tx_if
//   Read-port bundle between the 16-bit word FIFO and its UART drain stage.
//   master : FIFO side   (drives fifo_empty, fifo_valid, fifo_dout; sees fifo_rd)
//   slave  : drain side  (sees fifo_empty, fifo_valid, fifo_dout; drives fifo_rd)
//   Signals:
//     fifo_empty  FIFO has no words
//     fifo_valid  read data valid, answers a fifo_rd pop
//     fifo_dout   16-bit read data
//     fifo_rd     one-cycle pop strobe
// -----------------------------------------------------------------------------
interface fifo_uart_tx_if;
    logic        fifo_empty;
    logic        fifo_valid;
    logic [15:0] fifo_dout;
    logic        fifo_rd;

    modport master (
        output fifo_empty,
        output fifo_valid,
        output fifo_dout,
        input  fifo_rd
    );

    modport slave (
        input  fifo_empty,
        input  fifo_valid,
        input  fifo_dout,
        output fifo_rd
    );
endinterface

// File: rtl/fifo_uart_tx.sv
// -----------------------------------------------------------------------------
// fifo_uart_tx
//   Drain stage for the 16-bit word FIFO. While idle and enabled it pops one
//   word, then sends it on txd as two UART frames, low byte first.
//   Default framing is 8N1 (20 bit times per word). Defining the macro
//   UART_PARITY_EN adds an even-parity bit after the data bits of every byte
//   (22 bit times per word).
//
//   Parameter:
//     CLKS_PER_BIT  clk cycles per serial bit (>= 2)
//   Ports:
//     clk        system clock, rising edge
//     rst        asynchronous reset, active low
//     en         1 = allowed to fetch new words
//     fifo       FIFO read port (slave modport: empty/valid/dout in, rd out)
//     txd        serial line, idle high
//     busy       1 while the state machine is not idle
//     word_done  one-cycle pulse at the end of the high byte's stop bit
//     err        sticky: a pop was not answered by fifo_valid
//
//   Timing: txd is registered from the current state, so the line lags the
//   state machine by one cycle. The first start-bit edge appears two cycles
//   after fifo_rd rises, and word_done is delayed by the same extra cycle so
//   it lines up with the end of the stop bit on the line.
// -----------------------------------------------------------------------------
module fifo_uart_tx #(
    parameter int CLKS_PER_BIT = 868
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en,
    fifo_uart_tx_if.slave fifo,
    output logic          txd,
    output logic          busy,
    output logic          word_done,
    output logic          err
);

    localparam int            BW        = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_FETCH  = 3'd1;
    localparam logic [2:0] S_START  = 3'd2;
    localparam logic [2:0] S_DATA   = 3'd3;
    localparam logic [2:0] S_STOP   = 3'd4;
`ifdef UART_PARITY_EN
    localparam logic [2:0] S_PARITY = 3'd5;
`endif

    logic [2:0]    state_q,      state_d;
    logic [BW-1:0] baud_q,       baud_d;
    logic [2:0]    bit_idx_q,    bit_idx_d;
    logic          byte_sel_q,   byte_sel_d;
    logic [15:0]   shift_q,      shift_d;
    logic          txd_q,        txd_d;
    logic          fifo_rd_q,    fifo_rd_d;
    logic          busy_q,       busy_d;
    logic          done_early_q, done_early_d;
    logic          word_done_q,  word_done_d;
    logic          err_q,        err_d;

    logic [7:0]    cur_byte;
    logic          baud_end;

    assign cur_byte = byte_sel_q ? shift_q[15:8] : shift_q[7:0];
    assign baud_end = (baud_q == BAUD_LAST);

    always_comb begin
        state_d      = state_q;
        baud_d       = baud_q;
        bit_idx_d    = bit_idx_q;
        byte_sel_d   = byte_sel_q;
        shift_d      = shift_q;
        fifo_rd_d    = 1'b0;
        done_early_d = 1'b0;
        err_d        = err_q;

        case (state_q)
            S_IDLE: begin
                if (en && !fifo.fifo_empty) begin
                    fifo_rd_d = 1'b1;
                    state_d   = S_FETCH;
                end
            end
            S_FETCH: begin
                if (fifo.fifo_valid) begin
                    shift_d    = fifo.fifo_dout;
                    byte_sel_d = 1'b0;
                    baud_d     = '0;
                    bit_idx_d  = 3'd0;
                    state_d    = S_START;
                end else begin
                    // Pop went unanswered: flag it and give up on this word.
                    err_d   = 1'b1;
                    state_d = S_IDLE;
                end
            end
            S_START: begin
                if (baud_end) begin
                    baud_d  = '0;
                    state_d = S_DATA;
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            S_DATA: begin
                if (baud_end) begin
                    baud_d = '0;
                    if (bit_idx_q == 3'd7) begin
                        bit_idx_d = 3'd0;
`ifdef UART_PARITY_EN
                        state_d   = S_PARITY;
`else
                        state_d   = S_STOP;
`endif
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                    end
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
`ifdef UART_PARITY_EN
            S_PARITY: begin
                if (baud_end) begin
                    baud_d  = '0;
                    state_d = S_STOP;
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
`endif
            S_STOP: begin
                if (baud_end) begin
                    baud_d = '0;
                    if (!byte_sel_q) begin
                        // High byte follows immediately, no idle gap.
                        byte_sel_d = 1'b1;
                        state_d    = S_START;
                    end else begin
                        byte_sel_d   = 1'b0;
                        done_early_d = 1'b1;
                        state_d      = S_IDLE;
                    end
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d      = (state_d != S_IDLE);
        word_done_d = done_early_q;

        case (state_q)
            S_START:  txd_d = 1'b0;
            S_DATA:   txd_d = cur_byte[bit_idx_q];
`ifdef UART_PARITY_EN
            S_PARITY: txd_d = ^cur_byte;
`endif
            default:  txd_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= S_IDLE;
            baud_q       <= '0;
            bit_idx_q    <= 3'd0;
            byte_sel_q   <= 1'b0;
            shift_q      <= 16'h0000;
            txd_q        <= 1'b1;
            fifo_rd_q    <= 1'b0;
            busy_q       <= 1'b0;
            done_early_q <= 1'b0;
            word_done_q  <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            baud_q       <= baud_d;
            bit_idx_q    <= bit_idx_d;
            byte_sel_q   <= byte_sel_d;
            shift_q      <= shift_d;
            txd_q        <= txd_d;
            fifo_rd_q    <= fifo_rd_d;
            busy_q       <= busy_d;
            done_early_q <= done_early_d;
            word_done_q  <= word_done_d;
            err_q        <= err_d;
        end
    end

    assign fifo.fifo_rd = fifo_rd_q;
    assign txd          = txd_q;
    assign busy         = busy_q;
    assign word_done    = word_done_q;
    assign err          = err_q;

endmodule

// File: tb/tb_fifo_uart_tx.sv
// -----------------------------------------------------------------------------
// tb_fifo_uart_tx
//   Directed bench for fifo_uart_tx with CLKS_PER_BIT = 4. A small FIFO model
//   answers each pop with fifo_valid in the cycle the strobe is visible.
//   Build with +define+UART_PARITY_EN to exercise the parity framing.
// -----------------------------------------------------------------------------
module tb_fifo_uart_tx;

    localparam int CPB = 4;
`ifdef UART_PARITY_EN
    localparam int LINE = 22 * CPB;
`else
    localparam int LINE = 20 * CPB;
`endif

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic en  = 1'b0;
    logic txd, busy, word_done, err;

    fifo_uart_tx_if fif();

    fifo_uart_tx #(.CLKS_PER_BIT(CPB)) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .fifo      (fif.slave),
        .txd       (txd),
        .busy      (busy),
        .word_done (word_done),
        .err       (err)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_bad = 0;
    int cyc   = 0;
    int rd_cnt = 0;
    logic [15:0] fq[$];
    bit block_valid = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // FIFO model: serves pops from fq, updates inputs away from the rising edge.
    initial begin : fifo_model
        logic [15:0] w;
        fif.fifo_empty = 1'b1;
        fif.fifo_valid = 1'b0;
        fif.fifo_dout  = 16'hFFFF;
        forever begin
            @(negedge clk);
            if (fif.fifo_rd === 1'b1) begin
                rd_cnt++;
                if (fq.size() > 0) begin
                    w = fq.pop_front();
                    fif.fifo_valid = !block_valid;
                    fif.fifo_dout  = block_valid ? 16'hFFFF : w;
                end else begin
                    fif.fifo_valid = 1'b0;
                    fif.fifo_dout  = 16'hFFFF;
                end
            end else begin
                fif.fifo_valid = 1'b0;
                fif.fifo_dout  = 16'hFFFF;
            end
            fif.fifo_empty = (fq.size() == 0);
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic wait_rd(input string tag, output int t);
        t = -1;
        for (int k = 0; k < 400; k++) begin
            @(negedge clk);
            if (fif.fifo_rd === 1'b1) begin
                t = cyc;
                break;
            end
        end
        if (t < 0) check({tag, " rd timeout"}, 32'd0, 32'd1);
    endtask

    task automatic wait_fall(input string tag, output int t);
        t = -1;
        for (int k = 0; k < 400; k++) begin
            @(negedge clk);
            if (txd === 1'b0) begin
                t = cyc;
                break;
            end
        end
        if (t < 0) check({tag, " start timeout"}, 32'd0, 32'd1);
    endtask

    task automatic wait_wd(input string tag, output int t);
        t = -1;
        for (int k = 0; k < 400; k++) begin
            @(negedge clk);
            if (word_done === 1'b1) begin
                t = cyc;
                break;
            end
        end
        if (t < 0) check({tag, " word_done timeout"}, 32'd0, 32'd1);
    endtask

    // Entered at the first negedge after the start edge; samples mid-bit.
    task automatic chk_byte(input string tag, input logic [7:0] b);
        repeat (CPB / 2) @(negedge clk);
        check({tag, " start"}, {31'd0, txd}, 32'd0);
        for (int i = 0; i < 8; i++) begin
            repeat (CPB) @(negedge clk);
            check($sformatf("%s bit%0d", tag, i), {31'd0, txd}, {31'd0, b[i]});
        end
`ifdef UART_PARITY_EN
        repeat (CPB) @(negedge clk);
        check({tag, " parity"}, {31'd0, txd}, {31'd0, ^b});
`endif
        repeat (CPB) @(negedge clk);
        check({tag, " stop"}, {31'd0, txd}, 32'd1);
    endtask

    task automatic xfer_word(input string tag, input logic [15:0] w,
                             output int t_fall, output int t_wd);
        int t1;
        wait_fall(tag, t_fall);
        chk_byte({tag, " b0"}, w[7:0]);
        wait_fall(tag, t1);
        check({tag, " byte spacing"}, t1 - t_fall, LINE / 2);
        chk_byte({tag, " b1"}, w[15:8]);
        wait_wd(tag, t_wd);
        check({tag, " word length"}, t_wd - t_fall, LINE);
        @(negedge clk);
        check({tag, " word_done width"}, {31'd0, word_done}, 32'd0);
    endtask

    initial begin
        int t_rd, tf1, tw1, tf2, tw2, tf3, tw3, rd0;
        bit saw_low;

        // Reset state
        repeat (3) @(negedge clk);
        check("reset txd", {31'd0, txd}, 32'd1);
        check("reset busy", {31'd0, busy}, 32'd0);
        check("reset fifo_rd", {31'd0, fif.fifo_rd}, 32'd0);
        check("reset word_done", {31'd0, word_done}, 32'd0);
        check("reset err", {31'd0, err}, 32'd0);
        rst = 1'b1;
        repeat (2) @(negedge clk);

        // Single word, latency and framing
        fq.push_back(16'hA55A);
        @(negedge clk);
        en = 1'b1;
        wait_rd("single", t_rd);
        check("single busy", {31'd0, busy}, 32'd1);
        xfer_word("single", 16'hA55A, tf1, tw1);
        check("single rd->start", tf1 - t_rd, 32'd2);
        check("single idle busy", {31'd0, busy}, 32'd0);

        // Three queued words back to back
        en = 1'b0;
        @(negedge clk);
        rd0 = rd_cnt;
        fq.push_back(16'h0102);
        fq.push_back(16'hFF00);
        fq.push_back(16'h8001);
        @(negedge clk);
        en = 1'b1;
        xfer_word("burst w0", 16'h0102, tf1, tw1);
        xfer_word("burst w1", 16'hFF00, tf2, tw2);
        xfer_word("burst w2", 16'h8001, tf3, tw3);
        check("burst gap 0-1", tf2 - tw1, 32'd2);
        check("burst gap 1-2", tf3 - tw2, 32'd2);
        repeat (10) @(negedge clk);
        check("burst pops", rd_cnt - rd0, 32'd3);
        check("burst done busy", {31'd0, busy}, 32'd0);

        // en dropped during byte 0
        en = 1'b0;
        @(negedge clk);
        rd0 = rd_cnt;
        fq.push_back(16'h1234);
        fq.push_back(16'hBEEF);
        @(negedge clk);
        en = 1'b1;
        wait_rd("en drop", t_rd);
        fork
            begin
                repeat (6) @(negedge clk);
                en = 1'b0;
            end
        join_none
        xfer_word("en drop", 16'h1234, tf1, tw1);
        repeat (20) @(negedge clk);
        check("en drop pops", rd_cnt - rd0, 32'd1);
        check("en drop busy", {31'd0, busy}, 32'd0);
        check("en drop txd", {31'd0, txd}, 32'd1);
        en = 1'b1;
        xfer_word("resume", 16'hBEEF, tf1, tw1);

        // Pop not answered: sticky err, no frame
        en = 1'b0;
        block_valid = 1'b1;
        fq.push_back(16'h5555);
        repeat (2) @(negedge clk);
        en = 1'b1;
        wait_rd("no valid", t_rd);
        en = 1'b0;
        saw_low = 1'b0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (txd !== 1'b1) saw_low = 1'b1;
        end
        block_valid = 1'b0;
        check("no valid err", {31'd0, err}, 32'd1);
        check("no valid line quiet", {31'd0, saw_low}, 32'd0);
        check("no valid busy", {31'd0, busy}, 32'd0);
        fq.push_back(16'h00FF);
        @(negedge clk);
        en = 1'b1;
        xfer_word("after err", 16'h00FF, tf1, tw1);
        check("err sticky", {31'd0, err}, 32'd1);

        // Reset in the middle of DATA
        rd0 = rd_cnt;
        fq.push_back(16'h0000);
        wait_fall("mid reset", tf1);
        repeat (10) @(negedge clk);
        check("mid reset pre txd", {31'd0, txd}, 32'd0);
        check("mid reset pre busy", {31'd0, busy}, 32'd1);
        #2 rst = 1'b0;
        #1;
        check("mid reset txd", {31'd0, txd}, 32'd1);
        check("mid reset busy", {31'd0, busy}, 32'd0);
        check("mid reset fifo_rd", {31'd0, fif.fifo_rd}, 32'd0);
        check("mid reset err", {31'd0, err}, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        saw_low = 1'b0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (txd !== 1'b1 || busy !== 1'b0) saw_low = 1'b1;
        end
        check("post reset idle", {31'd0, saw_low}, 32'd0);
        check("post reset pops", rd_cnt - rd0, 32'd1);

`ifdef UART_PARITY_EN
        // Parity word: parity bits 1 (0x01) and 1 (0x07), 88-cycle word
        fq.push_back(16'h0701);
        xfer_word("parity", 16'h0701, tf1, tw1);
        check("parity word cycles", tw1 - tf1, 32'd88);
`endif

        en = 1'b0;
        repeat (4) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
